// File: rtl/stack_dump.sv
// Dumps words 0..depth-1 of the eval stack memory as a byte stream, MSB first.
// Define STACK_DUMP_HDR_EN to prefix the stream with the header bytes 0xA5, depth[7:0].
//   state  | meaning
//   IDLE   | waiting for start
//   HDR    | sending header bytes (STACK_DUMP_HDR_EN only)
//   READ   | issuing memory read for word idx
//   WAIT   | capturing read data
//   SEND   | streaming the four bytes of the current word
//   DONE   | one-cycle completion pulse
module stack_dump #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] depth,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

`ifdef STACK_DUMP_HDR_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR = 3'd1, S_READ = 3'd2, S_WAIT = 3'd3, S_SEND = 3'd4, S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_READ = 3'd2, S_WAIT = 3'd3, S_SEND = 3'd4, S_DONE = 3'd5
  } state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_inc;
  logic [31:0]       shreg;
  logic [1:0]        bcnt;

  assign idx_inc = idx + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef STACK_DUMP_HDR_EN
          state_nxt = S_HDR;
`else
          state_nxt = (depth != '0) ? S_READ : S_DONE;
`endif
        end
      end
`ifdef STACK_DUMP_HDR_EN
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = bcnt[0] ? 8'(count) : 8'hA5;
        if (tx_ready && bcnt[0])
          state_nxt = (count != '0) ? S_READ : S_DONE;
      end
`endif
      S_READ: begin
        rd_en     = 1'b1;
        rd_addr   = idx;
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_SEND;
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg[31:24];
        if (tx_ready && bcnt == 2'd3)
          state_nxt = (idx_inc == count) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      idx   <= '0;
      shreg <= '0;
      bcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= depth;
            idx   <= '0;
            bcnt  <= '0;
          end
        end
`ifdef STACK_DUMP_HDR_EN
        S_HDR: if (tx_ready) bcnt <= bcnt + 2'd1;
`endif
        S_WAIT: begin
          shreg <= rd_data;
          bcnt  <= '0;
        end
        S_SEND: begin
          if (tx_ready) begin
            shreg <= {shreg[23:0], 8'h00};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) idx <= idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
